// File: rtl/frame_deframer.sv
// Receive-side deframer: hunts for the frame header in the demodulated bitstream and extracts payloads.
// Optional DEFRAME_POLARITY_EN: accept an inverted header and de-invert the stream that follows it.
module frame_deframer #(
    parameter int HEADER  = 6,
    parameter int HDR_W   = 4,
    parameter int DATA_W  = 12,
    parameter int CONFIRM = 2,
    parameter int LOSS    = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              r_fsk_data,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] r_frame_data,
    output logic              frame_valid,
    output logic              frame_correct,
    output logic [1:0]        sync_state
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;

    localparam int CNT_W = (DATA_W > HDR_W) ? $clog2(DATA_W) : $clog2(HDR_W);

    localparam logic [HDR_W-1:0] HDR_PAT   = HDR_W'(HEADER);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       CONFIRM_C = 3'(CONFIRM);
    localparam logic [2:0]       LOSS_C    = 3'(LOSS);

    // Only HDR_W-1 history bits are kept; the incoming bit completes the window.
    logic [1:0]        state_q,      state_d;
    logic [HDR_W-2:0]  sr_q,         sr_d;
    logic [DATA_W-2:0] pay_q,        pay_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [2:0]        hit_q,        hit_d;
    logic [2:0]        miss_q,       miss_d;
    logic [DATA_W-1:0] frame_data_q, frame_data_d;
    logic              frame_vld_q,  frame_vld_d;
    logic              frame_ok_q,   frame_ok_d;
`ifdef DEFRAME_POLARITY_EN
    logic              inv_q,        inv_d;
`endif

    logic              bit_s;
    logic [HDR_W-1:0]  window_s;
    logic [2:0]        hit_inc_s;
    logic [2:0]        miss_inc_s;

    function automatic logic hdr_match(input logic [HDR_W-1:0] w);
        return (w == HDR_PAT);
    endfunction

`ifdef DEFRAME_POLARITY_EN
    assign bit_s = r_fsk_data ^ inv_q;
`else
    assign bit_s = r_fsk_data;
`endif

    assign window_s   = {sr_q, bit_s};
    assign hit_inc_s  = (hit_q  >= CONFIRM_C) ? hit_q  : hit_q  + 3'd1;
    assign miss_inc_s = (miss_q >= LOSS_C)    ? miss_q : miss_q + 3'd1;

    // Next-state logic for the hunt / payload / header-check sequencer.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        pay_d        = pay_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        frame_data_d = frame_data_q;
        frame_vld_d  = 1'b0;
        frame_ok_d   = frame_ok_q;
`ifdef DEFRAME_POLARITY_EN
        inv_d        = inv_q;
`endif
        if (bit_valid) begin
            case (state_q)
                ST_HUNT: begin
                    sr_d = window_s[HDR_W-2:0];
                    if (hdr_match(window_s)) begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = '0;
                        hit_d   = 3'd1;
                    end
`ifdef DEFRAME_POLARITY_EN
                    else if (hdr_match(~window_s)) begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = '0;
                        hit_d   = 3'd1;
                        inv_d   = 1'b1;
                    end
`endif
                    else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    pay_d = {pay_q[DATA_W-3:0], bit_s};
                    if (cnt_q == PAY_LAST) begin
                        frame_data_d = {pay_q, bit_s};
                        frame_vld_d  = 1'b1;
                        state_d      = ST_CHECK;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_CHECK: begin
                    sr_d = window_s[HDR_W-2:0];
                    if (cnt_q == HDR_LAST) begin
                        cnt_d = '0;
                        if (hdr_match(window_s)) begin
                            state_d = ST_PAYLOAD;
                            if (frame_ok_q) begin
                                miss_d = 3'd0;
                            end else begin
                                hit_d = hit_inc_s;
                                if (hit_inc_s >= CONFIRM_C) begin
                                    frame_ok_d = 1'b1;
                                    miss_d     = 3'd0;
                                end else begin
                                    frame_ok_d = 1'b0;
                                end
                            end
                        end else if (frame_ok_q) begin
                            // Flywheel: tolerate isolated bad headers while locked.
                            if (miss_inc_s >= LOSS_C) begin
                                frame_ok_d = 1'b0;
                                hit_d      = 3'd0;
                                miss_d     = 3'd0;
                                sr_d       = '0;
                                state_d    = ST_HUNT;
`ifdef DEFRAME_POLARITY_EN
                                inv_d      = 1'b0;
`endif
                            end else begin
                                miss_d  = miss_inc_s;
                                state_d = ST_PAYLOAD;
                            end
                        end else begin
                            hit_d   = 3'd0;
                            sr_d    = '0;
                            state_d = ST_HUNT;
`ifdef DEFRAME_POLARITY_EN
                            inv_d   = 1'b0;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= ST_HUNT;
            sr_q         <= '0;
            pay_q        <= '0;
            cnt_q        <= '0;
            hit_q        <= 3'd0;
            miss_q       <= 3'd0;
            frame_data_q <= '0;
            frame_vld_q  <= 1'b0;
            frame_ok_q   <= 1'b0;
`ifdef DEFRAME_POLARITY_EN
            inv_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            pay_q        <= pay_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            frame_data_q <= frame_data_d;
            frame_vld_q  <= frame_vld_d;
            frame_ok_q   <= frame_ok_d;
`ifdef DEFRAME_POLARITY_EN
            inv_q        <= inv_d;
`endif
        end
    end

    assign r_frame_data  = frame_data_q;
    assign frame_valid   = frame_vld_q;
    assign frame_correct = frame_ok_q;
    assign sync_state    = state_q;

endmodule

// File: tb/tb_frame_deframer.sv
// Directed bench for frame_deframer: lock, noise, flywheel, strobed input, mid-frame reset, polarity.
module tb_frame_deframer;

    logic        sys_clk;
    logic        sys_rst;
    logic        r_fsk_data;
    logic        bit_valid;
    logic [11:0] r_frame_data;
    logic        frame_valid;
    logic        frame_correct;
    logic [1:0]  sync_state;

    int errors;
    int checks;
    int fv_cnt;
    int fv_base;

    frame_deframer dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .r_fsk_data    (r_fsk_data),
        .bit_valid     (bit_valid),
        .r_frame_data  (r_frame_data),
        .frame_valid   (frame_valid),
        .frame_correct (frame_correct),
        .sync_state    (sync_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Counts frame_valid pulses so spurious payloads can be detected.
    always @(posedge sys_clk) begin
        if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends n bits of v MSB first, with gap idle cycles before each strobe.
    task automatic send_bits(input logic [15:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            repeat (gap) begin
                bit_valid = 1'b0;
                @(posedge sys_clk); #1;
            end
            r_fsk_data = v[i];
            bit_valid  = 1'b1;
            @(posedge sys_clk); #1;
            bit_valid  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) begin
            @(posedge sys_clk); #1;
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        fv_cnt     = 0;
        sys_rst    = 1'b0;
        r_fsk_data = 1'b0;
        bit_valid  = 1'b0;
        idle(2);
        chk("rst_data",  32'(r_frame_data),  32'h0);
        chk("rst_fv",    32'(frame_valid),   32'h0);
        chk("rst_fc",    32'(frame_correct), 32'h0);
        chk("rst_state", 32'(sync_state),    32'h0);
        sys_rst = 1'b1;
        idle(1);

        // Back-to-back frames: lock after the second header.
        send_bits(16'h0006, 4, 0);
        chk("t1_state_after_hdr", 32'(sync_state), 32'h1);
        send_bits(16'h0A5C, 12, 0);
        chk("t1_fv1",   32'(frame_valid),   32'h1);
        chk("t1_data1", 32'(r_frame_data),  32'hA5C);
        chk("t1_fc1",   32'(frame_correct), 32'h0);
        chk("t1_state_check", 32'(sync_state), 32'h2);
        send_bits(16'h0006, 4, 0);
        chk("t1_fc_lock", 32'(frame_correct), 32'h1);
        send_bits(16'h03F1, 12, 0);
        chk("t1_fv2",   32'(frame_valid),  32'h1);
        chk("t1_data2", 32'(r_frame_data), 32'h3F1);
        idle(1);
        chk("t1_fv_pulse", 32'(frame_valid), 32'h0);

        // Flywheel: two bad headers tolerated, third drops lock.
        send_bits(16'h0009, 4, 0);
        chk("t3_fc_miss1", 32'(frame_correct), 32'h1);
        send_bits(16'h0123, 12, 0);
        chk("t3_data1", 32'(r_frame_data), 32'h123);
        chk("t3_fv1",   32'(frame_valid),  32'h1);
        send_bits(16'h0009, 4, 0);
        chk("t3_fc_miss2", 32'(frame_correct), 32'h1);
        send_bits(16'h0456, 12, 0);
        chk("t3_data2", 32'(r_frame_data), 32'h456);
        send_bits(16'h0009, 4, 0);
        chk("t3_fc_lost",  32'(frame_correct), 32'h0);
        chk("t3_state_hunt", 32'(sync_state), 32'h0);

        // Noise without the header, then a frame.
        fv_base = fv_cnt;
        send_bits(16'h0014, 5, 0);
        chk("t2_noise_state", 32'(sync_state), 32'h0);
        send_bits(16'h0006, 4, 0);
        chk("t2_hdr_state", 32'(sync_state), 32'h1);
        send_bits(16'h0C3A, 12, 0);
        chk("t2_data", 32'(r_frame_data),  32'hC3A);
        chk("t2_fc",   32'(frame_correct), 32'h0);
        idle(1);
        chk("t2_fv_count", 32'(fv_cnt - fv_base), 32'h1);

        // Bad header while unlocked goes straight back to HUNT.
        send_bits(16'h000F, 4, 0);
        chk("t2b_state_hunt", 32'(sync_state), 32'h0);

        // One strobe every third cycle.
        send_bits(16'h0006, 4, 2);
        send_bits(16'h0A5C, 12, 2);
        chk("t4_fv1",   32'(frame_valid),  32'h1);
        chk("t4_data1", 32'(r_frame_data), 32'hA5C);
        idle(1);
        chk("t4_fv_pulse", 32'(frame_valid), 32'h0);
        send_bits(16'h0006, 4, 2);
        chk("t4_fc_lock", 32'(frame_correct), 32'h1);
        send_bits(16'h03F1, 12, 2);
        chk("t4_data2", 32'(r_frame_data), 32'h3F1);
        chk("t4_fv2",   32'(frame_valid),  32'h1);

        // Reset in the middle of a payload.
        send_bits(16'h0006, 4, 0);
        send_bits(16'h002D, 6, 0);
        sys_rst = 1'b0;
        #1;
        chk("t5_rst_data",  32'(r_frame_data),  32'h0);
        chk("t5_rst_fc",    32'(frame_correct), 32'h0);
        chk("t5_rst_state", 32'(sync_state),    32'h0);
        chk("t5_rst_fv",    32'(frame_valid),   32'h0);
        idle(2);
        sys_rst = 1'b1;
        fv_base = fv_cnt;
        send_bits(16'h002A, 6, 0);
        idle(1);
        chk("t5_no_fv", 32'(fv_cnt - fv_base), 32'h0);
        send_bits(16'h0006, 4, 0);
        send_bits(16'h05A5, 12, 0);
        chk("t5_data", 32'(r_frame_data), 32'h5A5);
        chk("t5_fv",   32'(frame_valid),  32'h1);

        // Inverted stream: 1001 + ~12'hE38 twice.
        sys_rst = 1'b0;
        idle(1);
        sys_rst = 1'b1;
        fv_base = fv_cnt;
        send_bits(16'h0009, 4, 0);
        send_bits(16'h01C7, 12, 0);
        send_bits(16'h0009, 4, 0);
        send_bits(16'h01C7, 12, 0);
`ifdef DEFRAME_POLARITY_EN
        chk("t6_data", 32'(r_frame_data),  32'hE38);
        chk("t6_fc",   32'(frame_correct), 32'h1);
        idle(1);
        chk("t6_fv_count", 32'(fv_cnt - fv_base), 32'h2);
`else
        chk("t6_state_hunt", 32'(sync_state),    32'h0);
        chk("t6_fc",         32'(frame_correct), 32'h0);
        idle(1);
        chk("t6_fv_count", 32'(fv_cnt - fv_base), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
